ncl_serial_adder: RTL and testbench
===================================

NCL_SERIAL_ADDER -- requirements
Module: ncl_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand word length in digits (bits), legal range 2..32.
REQ-002 SHALL have parameter SIGNED, default 1; 1 enables two's-complement overflow reporting, 0 leaves ovf at NULL.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, sole clock, all state on rising edge.
REQ-004 initN input 1: asynchronous active-low reset.
REQ-005 A input 2: dual-rail operand digit, LSB-first.
REQ-006 B input 2: dual-rail operand digit, LSB-first.
REQ-007 inCOMP output 1: upstream completion; 0 requests DATA, 1 requests NULL.
REQ-008 sum output 2: dual-rail sum digit.
REQ-009 carryout output 2: dual-rail word carry; DATA only with the MSB digit, else NULL.
REQ-010 ovf output 2: dual-rail signed overflow; DATA only with the MSB digit when SIGNED=1, else NULL.
REQ-011 sumCOMP input 1: downstream completion; 0 requests DATA, 1 requests NULL.
REQ-012 err output 1: sticky flag, illegal codeword seen.

Function
REQ-013 Dual-rail encoding SHALL be 00 NULL, 01 value 0, 10 value 1, 11 illegal.
REQ-014 FSM SHALL have two states: REQD (inCOMP=0) and REQN (inCOMP=1).
REQ-015 In REQD, when A and B are both DATA and sumCOMP=0, the next edge SHALL register sum = A^B^c, update carry c, drive carryout/ovf per REQ-018, and enter REQN; latency one clock.
REQ-016 In REQD, a single DATA operand or sumCOMP=1 SHALL hold all outputs and state.
REQ-017 In REQN, when A and B are both NULL and sumCOMP=1, the next edge SHALL drive sum, carryout and ovf to NULL, advance the digit index, and enter REQD; otherwise hold.
REQ-018 At digit index WIDTH-1, carryout SHALL equal the carry out of the MSB, and ovf (SIGNED=1) SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-019 Digit index SHALL wrap from WIDTH-1 to 0 on the NULL edge of REQ-017, and c SHALL clear to 0 at that same edge.
REQ-020 Any 11 on A or B in any state SHALL set err; the digit SHALL NOT be consumed and the FSM SHALL hold until the illegal codeword leaves the input.
REQ-021 Only reset SHALL clear err.
REQ-022 Outputs SHALL be registered; no combinational path from A, B or sumCOMP to any output.

Reset
REQ-023 initN low SHALL asynchronously force sum=00, carryout=00, ovf=00, inCOMP=0, err=0, state REQD, digit index 0, c=0.
REQ-024 Reset mid-word SHALL discard the partial word; the first DATA pair after release SHALL be digit 0.
REQ-025 Reset release SHALL take effect on the first clk edge after initN rises.

Structure
REQ-026 Package ncl_pkg SHALL hold the dual-rail codeword constants (DR_NULL, DR_0, DR_1, DR_ILL) and the FSM state enum.
REQ-027 The per-digit dual-rail full-adder logic SHALL be sub-module ncl_dr_fa, taking A, B and carry-in and returning sum and carry digits, including their DATA and NULL states.
REQ-028 The top level SHALL contain the FSM, the digit counter, the carry register, the err flag and the output registers.

Verification
REQ-029 WIDTH=8, SIGNED=0, 0x5A+0x3C fed LSB-first with a full four-phase handshake -> sum digits 0x96, carryout=01 on digit 7, NULL elsewhere.
REQ-030 SIGNED=1, 0x7F+0x01 -> sum 0x80, ovf=10, carryout=01; then 0xFF+0x01 -> sum 0x00, ovf=01, carryout=10.
REQ-031 Backpressure: sumCOMP held 1 while a DATA pair waits in REQD -> sum stays NULL and inCOMP stays 0; one clock after sumCOMP=0, sum is DATA.
REQ-032 Skew: A DATA three cycles before B -> no state change until B is DATA; result is correct.
REQ-033 Illegal input: A=11 on digit 2 -> err=1 next edge, digit not consumed; a following legal DATA/NULL sequence completes the word and err stays 1.
REQ-034 Reset after digit 4 of 0xFF+0xFF -> all outputs 00, inCOMP=0; next word 0x01+0x01 yields sum 0x02, carryout=01.

Source files
------------

// File: rtl/ncl_pkg.sv
// Dual-rail codeword constants, handshake FSM states and small helpers shared by the
// NCL serial adder. Each digit is two rails: 00 NULL, 01 value 0, 10 value 1, 11 illegal.
package ncl_pkg;

  typedef logic [1:0] dr_t;

  localparam dr_t DR_NULL = 2'b00;
  localparam dr_t DR_0    = 2'b01;
  localparam dr_t DR_1    = 2'b10;
  localparam dr_t DR_ILL  = 2'b11;

  typedef enum logic {
    REQD = 1'b0,
    REQN = 1'b1
  } state_t;

  function automatic logic dr_is_data(input dr_t d);
    return (d == DR_0) || (d == DR_1);
  endfunction

  function automatic logic dr_is_null(input dr_t d);
    return d == DR_NULL;
  endfunction

  function automatic logic dr_is_ill(input dr_t d);
    return d == DR_ILL;
  endfunction

  // The true rail carries the value of a DATA digit.
  function automatic logic dr_val(input dr_t d);
    return d[1];
  endfunction

  function automatic dr_t dr_enc(input logic v);
    return v ? DR_1 : DR_0;
  endfunction

endpackage

// File: rtl/ncl_serial_adder_if.sv
// Four-phase dual-rail link between operand source, adder and result sink.
// The adder sits on the slave modport; the environment drives through master.
interface ncl_serial_adder_if;
  import ncl_pkg::*;

  dr_t  A;
  dr_t  B;
  logic inCOMP;
  dr_t  sum;
  dr_t  carryout;
  dr_t  ovf;
  logic sumCOMP;

  modport master (
    output A,
    output B,
    output sumCOMP,
    input  inCOMP,
    input  sum,
    input  carryout,
    input  ovf
  );

  modport slave (
    input  A,
    input  B,
    input  sumCOMP,
    output inCOMP,
    output sum,
    output carryout,
    output ovf
  );

endinterface

// File: rtl/ncl_dr_fa.sv
// Dual-rail full adder, combinational: sum and carry are DATA only once a, b and cin
// are all DATA, and NULL otherwise (including when any input holds an illegal 11).
module ncl_dr_fa
  import ncl_pkg::*;
(
  input  dr_t a,
  input  dr_t b,
  input  dr_t cin,
  output dr_t s,
  output dr_t co
);

  logic all_data;
  logic av, bv, cv;

  always_comb begin
    all_data = dr_is_data(a) && dr_is_data(b) && dr_is_data(cin);
    av       = dr_val(a);
    bv       = dr_val(b);
    cv       = dr_val(cin);
  end

  always_comb begin
    s  = DR_NULL;
    co = DR_NULL;
    if (all_data) begin
      s  = dr_enc(av ^ bv ^ cv);
      co = dr_enc((av & bv) | (av & cv) | (bv & cv));
    end
  end

endmodule

// File: rtl/ncl_serial_adder.sv
// LSB-first dual-rail serial adder; one clock from a complete DATA pair to a registered sum.
// Stalls in REQD while sumCOMP=1 or an operand is missing, and in REQN until both inputs and sink are NULL.
module ncl_serial_adder
  import ncl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 initN,
  ncl_serial_adder_if.slave    bus,
  output logic                 err
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          c_q;
  dr_t           sum_q, co_q, ovf_q;
  logic          err_q;
  logic          incomp;

  logic ill, both_data, both_null, last, take_data, take_null;
  dr_t  cin_dr, fa_s, fa_co;

  always_comb begin
    ill       = dr_is_ill(bus.A) || dr_is_ill(bus.B);
    both_data = dr_is_data(bus.A) && dr_is_data(bus.B);
    both_null = dr_is_null(bus.A) && dr_is_null(bus.B);
    last      = (idx_q == LAST_IDX);
    cin_dr    = dr_enc(c_q);
    take_data = (state_q == REQD) && !ill && both_data && !bus.sumCOMP;
    take_null = (state_q == REQN) && !ill && both_null && bus.sumCOMP;
  end

  ncl_dr_fa u_fa (
    .a   (bus.A),
    .b   (bus.B),
    .cin (cin_dr),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk or negedge initN) begin
    if (!initN) begin
      state_q <= REQD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQD:    if (take_data) state_d = REQN;
      REQN:    if (take_null) state_d = REQD;
      default: state_d = REQD;
    endcase
  end

  always_comb begin
    incomp = (state_q == REQN);
  end

  // Carry register holds the carry into the current digit; it restarts at the word boundary.
  always_ff @(posedge clk or negedge initN) begin
    if (!initN) begin
      idx_q <= '0;
      c_q   <= 1'b0;
      sum_q <= DR_NULL;
      co_q  <= DR_NULL;
      ovf_q <= DR_NULL;
      err_q <= 1'b0;
    end else begin
      if (ill) begin
        err_q <= 1'b1;
      end
      if (take_data) begin
        sum_q <= fa_s;
        c_q   <= dr_val(fa_co);
        if (last) begin
          co_q  <= fa_co;
          ovf_q <= SIGNED ? dr_enc(c_q ^ dr_val(fa_co)) : DR_NULL;
        end
      end else if (take_null) begin
        sum_q <= DR_NULL;
        co_q  <= DR_NULL;
        ovf_q <= DR_NULL;
        if (last) begin
          idx_q <= '0;
          c_q   <= 1'b0;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  assign bus.inCOMP   = incomp;
  assign bus.sum      = sum_q;
  assign bus.carryout = co_q;
  assign bus.ovf      = ovf_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ncl_serial_adder.sv
// Drives two adders (unsigned and signed) with identical four-phase traffic and checks
// each registered digit against word-level arithmetic.
module tb_ncl_serial_adder;

  localparam int W = 8;
  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] ILL = 2'b11;

  logic clk = 1'b0;
  logic initN = 1'b0;
  logic err0, err1;
  logic exp_err = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ncl_serial_adder_if b0();
  ncl_serial_adder_if b1();

  ncl_serial_adder #(.WIDTH(W), .SIGNED(1'b0)) u_uns (
    .clk(clk), .initN(initN), .bus(b0), .err(err0));
  ncl_serial_adder #(.WIDTH(W), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .initN(initN), .bus(b1), .err(err1));

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic sc);
    b0.A = a; b1.A = a;
    b0.B = b; b1.B = b;
    b0.sumCOMP = sc; b1.sumCOMP = sc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One word through the full handshake; optional operand skew, sink backpressure and
  // an illegal A codeword on digit ill_dig. ndig < W stops part-way through the word.
  task automatic run_word(input logic [W-1:0] x, input logic [W-1:0] y, input int ndig,
                          input int skew, input int bp, input int ill_dig);
    logic [W:0] full;
    logic       ov;
    logic [1:0] es, eco, eov;
    full = {1'b0, x} + {1'b0, y};
    ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    for (int i = 0; i < ndig; i++) begin
      for (int k = 0; k < skew; k++) begin
        drive(enc(x[i]), NUL, 1'b0);
        step();
        checks++;
        if ({b0.inCOMP, b0.sum, b1.inCOMP, b1.sum, err0, err1} !== {1'b0, NUL, 1'b0, NUL, exp_err, exp_err}) begin
          errors++;
          $display("FAIL skew_hold digit %0d: inCOMP %b/%b sum %b/%b err %b/%b, want inCOMP 0 sum 00 err %b",
                   i, b0.inCOMP, b1.inCOMP, b0.sum, b1.sum, err0, err1, exp_err);
        end
      end
      for (int k = 0; k < bp; k++) begin
        drive(enc(x[i]), enc(y[i]), 1'b1);
        step();
        checks++;
        if ({b0.inCOMP, b0.sum, b1.inCOMP, b1.sum, err0, err1} !== {1'b0, NUL, 1'b0, NUL, exp_err, exp_err}) begin
          errors++;
          $display("FAIL backpressure_hold digit %0d: inCOMP %b/%b sum %b/%b err %b/%b, want inCOMP 0 sum 00 err %b",
                   i, b0.inCOMP, b1.inCOMP, b0.sum, b1.sum, err0, err1, exp_err);
        end
      end
      if (i == ill_dig) begin
        exp_err = 1'b1;
        for (int k = 0; k < 2; k++) begin
          drive(ILL, enc(y[i]), 1'b0);
          step();
          checks++;
          if ({b0.inCOMP, b0.sum, b1.inCOMP, b1.sum, err0, err1} !== {1'b0, NUL, 1'b0, NUL, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_hold digit %0d: inCOMP %b/%b sum %b/%b err %b/%b, want inCOMP 0 sum 00 err 1",
                     i, b0.inCOMP, b1.inCOMP, b0.sum, b1.sum, err0, err1);
          end
        end
      end
      es  = enc(full[i]);
      eco = (i == W-1) ? enc(full[W]) : NUL;
      eov = (i == W-1) ? enc(ov) : NUL;
      drive(enc(x[i]), enc(y[i]), 1'b0);
      step();
      checks++;
      if ({b0.inCOMP, b0.sum, b1.inCOMP, b1.sum, err0, err1} !== {1'b1, es, 1'b1, es, exp_err, exp_err}) begin
        errors++;
        $display("FAIL data_sum digit %0d (%h+%h): inCOMP %b/%b sum %b/%b err %b/%b, want inCOMP 1 sum %b err %b",
                 i, x, y, b0.inCOMP, b1.inCOMP, b0.sum, b1.sum, err0, err1, es, exp_err);
      end
      checks++;
      if ({b0.carryout, b1.carryout, b0.ovf, b1.ovf} !== {eco, eco, NUL, eov}) begin
        errors++;
        $display("FAIL data_flags digit %0d (%h+%h): carryout %b/%b ovf %b/%b, want carryout %b ovf 00/%b",
                 i, x, y, b0.carryout, b1.carryout, b0.ovf, b1.ovf, eco, eov);
      end
      drive(NUL, NUL, 1'b1);
      step();
      checks++;
      if ({b0.inCOMP, b0.sum, b0.carryout, b0.ovf, b1.inCOMP, b1.sum, b1.carryout, b1.ovf}
          !== {1'b0, NUL, NUL, NUL, 1'b0, NUL, NUL, NUL}) begin
        errors++;
        $display("FAIL null_phase digit %0d: inCOMP %b/%b sum %b/%b carryout %b/%b ovf %b/%b, want inCOMP 0 all 00",
                 i, b0.inCOMP, b1.inCOMP, b0.sum, b1.sum, b0.carryout, b1.carryout, b0.ovf, b1.ovf);
      end
    end
    drive(NUL, NUL, 1'b0);
  endtask

  task automatic test_reset();
    initN = 1'b0;
    drive(NUL, NUL, 1'b0);
    @(negedge clk);
    checks++;
    if ({b0.inCOMP, b0.sum, b0.carryout, b0.ovf, err0, b1.inCOMP, b1.sum, b1.carryout, b1.ovf, err1} !== '0) begin
      errors++;
      $display("FAIL reset_state: inCOMP %b/%b sum %b/%b carryout %b/%b ovf %b/%b err %b/%b, want all 0",
               b0.inCOMP, b1.inCOMP, b0.sum, b1.sum, b0.carryout, b1.carryout, b0.ovf, b1.ovf, err0, err1);
    end
    initN = 1'b1;
    step();
    checks++;
    if ({b0.inCOMP, b0.sum, b1.inCOMP, b1.sum} !== {1'b0, NUL, 1'b0, NUL}) begin
      errors++;
      $display("FAIL reset_release_idle: inCOMP %b/%b sum %b/%b, want 0 00",
               b0.inCOMP, b1.inCOMP, b0.sum, b1.sum);
    end
  endtask

  task automatic test_directed();
    run_word(8'h5A, 8'h3C, W, 0, 0, -1);
    run_word(8'h7F, 8'h01, W, 0, 0, -1);
    run_word(8'hFF, 8'h01, W, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    run_word(8'hC3, 8'h5E, W, 0, 3, -1);
  endtask

  task automatic test_skew();
    run_word(8'h96, 8'hA7, W, 3, 0, -1);
  endtask

  task automatic test_illegal();
    run_word(8'h12, 8'h34, W, 0, 0, 2);
    run_word(8'h80, 8'h80, W, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      run_word(W'($urandom), W'($urandom), W, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
  endtask

  task automatic test_reset_midword();
    run_word(8'hFF, 8'hFF, 5, 0, 0, -1);
    drive(2'b10, 2'b10, 1'b0);
    step();
    initN = 1'b0;
    #1;
    exp_err = 1'b0;
    checks++;
    if ({b0.inCOMP, b0.sum, b0.carryout, b0.ovf, err0, b1.inCOMP, b1.sum, b1.carryout, b1.ovf, err1} !== '0) begin
      errors++;
      $display("FAIL midword_reset_async: inCOMP %b/%b sum %b/%b carryout %b/%b ovf %b/%b err %b/%b, want all 0",
               b0.inCOMP, b1.inCOMP, b0.sum, b1.sum, b0.carryout, b1.carryout, b0.ovf, b1.ovf, err0, err1);
    end
    drive(NUL, NUL, 1'b0);
    @(negedge clk);
    initN = 1'b1;
    step();
    run_word(8'h01, 8'h01, W, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_skew();
    test_illegal();
    test_random();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
